// File: rtl/mips_result_monitor.sv
// ---------------------------------------------------------------------------
// mips_result_monitor
//   Watches the core's MTC0 pass/done reporting interface. It classifies
//   report codes, counts PASS reports, and counts cycles and retired
//   instructions from soft-reset release. A DONE or FAIL report freezes
//   every statistic. The frozen values go to the LEDs and to a
//   selectable readout word.
//
// Ports
//   clk          core clock
//   rst_n        asynchronous active-low hard reset
//   soft_rst_n   synchronous soft reset (0 = hold in IDLE, 1 = run)
//   report_valid one-cycle MTC0 report strobe
//   report_code  report code (PASS / FAIL / DONE / other)
//   report_pc    PC of the reporting MTC0
//   retire       one instruction retired this cycle
//   rd_sel       readout select: 0 cycles, 1 instructions, 2 passes, 3 fail PC
//   rd_data      selected statistic, registered
//   state        0 IDLE, 1 RUN, 2 DONE, 3 FAIL
//   finished     high in DONE or FAIL
//   leds         {finished, fail, pass_count[7:0]}, registered
// ---------------------------------------------------------------------------
module mips_result_monitor #(
  parameter int                CODE_W    = 4,
  parameter logic [CODE_W-1:0] CODE_PASS = 4'h1,
  parameter logic [CODE_W-1:0] CODE_FAIL = 4'h2,
  parameter logic [CODE_W-1:0] CODE_DONE = 4'h3,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst_n,
  input  logic              report_valid,
  input  logic [CODE_W-1:0] report_code,
  input  logic [31:0]       report_pc,
  input  logic              retire,
  input  logic [1:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [1:0]        state,
  output logic              finished,
  output logic [9:0]        leds
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;
  logic [CNT_W-1:0] instrs_reg, instrs_next;
  logic [CNT_W-1:0] passes_reg, passes_next;
  logic [31:0]      fail_pc_reg, fail_pc_next;

  // Saturating increment: a counter that reaches all-ones holds there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_next   = state_reg;
    cycles_next  = cycles_reg;
    instrs_next  = instrs_reg;
    passes_next  = passes_reg;
    fail_pc_next = fail_pc_reg;

    if (!soft_rst_n) begin
      // Soft reset takes priority over any report or retire in the same cycle.
      state_next   = ST_IDLE;
      cycles_next  = '0;
      instrs_next  = '0;
      passes_next  = '0;
      fail_pc_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // The release edge is the first counted cycle.
          state_next  = ST_RUN;
          cycles_next = sat_inc(cycles_reg);
          if (retire) instrs_next = sat_inc(instrs_reg);
        end
        ST_RUN: begin
          // The terminating cycle still counts, including its retire.
          cycles_next = sat_inc(cycles_reg);
          if (retire) instrs_next = sat_inc(instrs_reg);
          if (report_valid) begin
            if (report_code == CODE_PASS) begin
              passes_next = sat_inc(passes_reg);
            end else if (report_code == CODE_DONE) begin
              state_next = ST_DONE;
            end else if (report_code == CODE_FAIL) begin
              state_next   = ST_FAIL;
              fail_pc_next = report_pc;
            end
          end
        end
        default: ; // DONE / FAIL: sticky and frozen
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cycles_reg  <= '0;
      instrs_reg  <= '0;
      passes_reg  <= '0;
      fail_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cycles_reg  <= cycles_next;
      instrs_reg  <= instrs_next;
      passes_reg  <= passes_next;
      fail_pc_reg <= fail_pc_next;
    end
  end

  assign state    = state_reg;
  assign finished = (state_reg == ST_DONE) || (state_reg == ST_FAIL);

  // Readout and LEDs are registered from the current register values.
  // They therefore lag a counter update by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      leds    <= '0;
    end else begin
      case (rd_sel)
        2'd0:    rd_data <= cycles_reg;
        2'd1:    rd_data <= instrs_reg;
        2'd2:    rd_data <= passes_reg;
        default: rd_data <= (state_reg == ST_FAIL) ? CNT_W'(fail_pc_reg) : '0;
      endcase
      leds <= {finished, state_reg == ST_FAIL, passes_reg[7:0]};
    end
  end

endmodule

// File: tb/tb_mips_result_monitor.sv
module tb_mips_result_monitor;

  logic        clk = 1'b0;
  logic        rst_n, soft_rst_n, report_valid, retire;
  logic [3:0]  report_code;
  logic [31:0] report_pc;
  logic [1:0]  rd_sel;

  logic [31:0] rd_data;
  logic [1:0]  state;
  logic        finished;
  logic [9:0]  leds;

  logic [7:0]  rd_data_s;
  logic [1:0]  state_s;
  logic        finished_s;
  logic [9:0]  leds_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_result_monitor dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_n(soft_rst_n),
    .report_valid(report_valid), .report_code(report_code),
    .report_pc(report_pc), .retire(retire), .rd_sel(rd_sel),
    .rd_data(rd_data), .state(state), .finished(finished), .leds(leds)
  );

  // Narrow-counter build used for the saturation case; shares all inputs.
  mips_result_monitor #(.CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .soft_rst_n(soft_rst_n),
    .report_valid(report_valid), .report_code(report_code),
    .report_pc(report_pc), .retire(retire), .rd_sel(rd_sel),
    .rd_data(rd_data_s), .state(state_s), .finished(finished_s), .leds(leds_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic report(input logic [3:0] code, input logic [31:0] pc);
    report_valid = 1'b1;
    report_code  = code;
    report_pc    = pc;
    tick();
    report_valid = 1'b0;
    report_code  = 4'h0;
    report_pc    = 32'h0;
  endtask

  task automatic read(input logic [1:0] sel);
    rd_sel = sel;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; soft_rst_n = 1'b0; report_valid = 1'b0; retire = 1'b0;
    report_code = 4'h0; report_pc = 32'h0; rd_sel = 2'd0;

    // Hard reset state
    tick(); tick();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_finished", {31'd0, finished}, 32'd0);
    check("rst_leds", {22'd0, leds}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", {30'd0, state}, 32'd0);

    // 100 cycles with retire on alternate cycles, then DONE
    soft_rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      retire = (i % 2 == 1);
      tick();
    end
    retire = 1'b0;
    report(4'h3, 32'h0);
    check("done_state", {30'd0, state}, 32'd2);
    check("done_finished", {31'd0, finished}, 32'd1);
    read(2'd0); check("done_cycles", rd_data, 32'd101);
    read(2'd1); check("done_instrs", rd_data, 32'd50);
    check("done_leds", {22'd0, leds}, 32'h200);
    // Frozen: retires and reports are ignored
    retire = 1'b1;
    for (int i = 0; i < 20; i++) begin
      report_valid = (i % 3 == 0);
      report_code  = (i % 2 == 0) ? 4'h1 : 4'h2;
      tick();
    end
    retire = 1'b0; report_valid = 1'b0; report_code = 4'h0;
    read(2'd0); check("frozen_cycles", rd_data, 32'd101);
    read(2'd1); check("frozen_instrs", rd_data, 32'd50);
    read(2'd2); check("frozen_passes", rd_data, 32'd0);
    check("frozen_state", {30'd0, state}, 32'd2);

    // Soft reset from DONE, then restart
    soft_rst_n = 1'b0;
    tick();
    check("soft_state", {30'd0, state}, 32'd0);
    check("soft_finished", {31'd0, finished}, 32'd0);
    read(2'd0); check("soft_cycles", rd_data, 32'd0);
    read(2'd1); check("soft_instrs", rd_data, 32'd0);
    soft_rst_n = 1'b1;
    tick();
    check("restart_state", {30'd0, state}, 32'd1);
    read(2'd0); check("restart_cycles", rd_data, 32'd1);

    // PASS x5 back-to-back, then FAIL
    rd_sel = 2'd3;
    for (int i = 0; i < 5; i++) report(4'h1, 32'h0);
    check("run_failpc_zero", rd_data, 32'd0);
    report(4'h2, 32'h0040_0124);
    check("fail_state", {30'd0, state}, 32'd3);
    check("fail_rd_lag", rd_data, 32'd0);
    tick();
    check("fail_pc", rd_data, 32'h0040_0124);
    check("fail_leds", {22'd0, leds}, 32'h305);
    read(2'd2); check("fail_passes", rd_data, 32'd5);

    // Unknown code ignored; DONE with a simultaneous retire counts it
    soft_rst_n = 1'b0; tick();
    soft_rst_n = 1'b1; tick();
    report(4'h7, 32'h1234);
    check("unk_state", {30'd0, state}, 32'd1);
    read(2'd2); check("unk_passes", rd_data, 32'd0);
    retire = 1'b1;
    report(4'h3, 32'h0);
    retire = 1'b0;
    check("done_retire_state", {30'd0, state}, 32'd2);
    read(2'd1); check("done_retire_instrs", rd_data, 32'd1);

    // Saturation of the 8-bit build
    soft_rst_n = 1'b0; tick();
    soft_rst_n = 1'b1; tick();
    for (int i = 0; i < 300; i++) tick();
    read(2'd0);
    check("sat_cycles8", {24'd0, rd_data_s}, 32'd255);
    check("wide_cycles", rd_data, 32'd301);
    tick();
    check("sat_hold8", {24'd0, rd_data_s}, 32'd255);

    // Asynchronous hard reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("async_state", {30'd0, state}, 32'd0);
    check("async_rd_data", rd_data, 32'd0);
    check("async_rd_data8", {24'd0, rd_data_s}, 32'd0);
    check("async_leds", {22'd0, leds}, 32'd0);
    check("async_finished", {31'd0, finished}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
